// File: rtl/period_meter.sv
// Measures rising-edge-to-rising-edge period of a slow external signal.
// Reports each period with a one-cycle strobe and flags loss of signal.
module period_meter #(
  parameter int          COUNT_WIDTH = 32,
  parameter int unsigned MAX_PERIOD  = 24000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   timeout,
  output logic                   busy
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST =
    COUNT_WIDTH'(MAX_PERIOD - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   sync1;
  logic                   sync2;
  logic                   sync2_d;
  logic                   rise;
  logic                   at_last;
  logic [COUNT_WIDTH-1:0] cnt;

  // Two-flop synchronizer plus delay tap; preset high so a
  // signal already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync2_d <= 1'b1;
    end else begin
      sync1   <= sig_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise    = sync2 & ~sync2_d;
  assign at_last = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: first edge arms, a missing edge drops back to idle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!rise && at_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Busy reflects the measuring state directly.
  always_comb begin
    busy = (state == MEASURE);
  end

  // Period counter and result registers; an edge on the final
  // count still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period  <= cnt + 1'b1;
            valid   <= 1'b1;
            cnt     <= '0;
            timeout <= 1'b0;
          end else if (at_last) begin
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
